wb_group_arbiter: RTL and testbench

// - Shares the single multicycle writeback group (WB group 1) between NUM_UNITS multicycle execution units.
// - Its output drives wb_packet[1], which feeds commit-packet generation and the ID waiting-for-writeback tracking.
// - Picks one completed unit per cycle and registers its result onto the WB port.
// - The unit holding the oldest in-flight ID wins over round-robin, so retirement never blocks behind a younger result.

---
 rtl/cva5_types.sv | 21 ++
 rtl/rr_priority_picker.sv | 43 ++++
 rtl/wb_group_arbiter.sv | 118 +++++++++++
 tb/tb_wb_group_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/cva5_types.sv
// Shared types for the writeback path: instruction IDs, the
// multicycle-unit writeback request bundle and index-width helper.
package cva5_types;

   localparam int LOG2_MAX_IDS = 4;
   localparam int MAX_DATA_W   = 32;

   typedef logic [LOG2_MAX_IDS-1:0] id_t;

   typedef struct packed {
      logic                  done;
      id_t                   id;
      logic [MAX_DATA_W-1:0] rd;
   } wb_arb_req_t;

   // Index width for an n-entry vector, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set request at or after i_start, wrapping.
// Ports: i_req request vector, i_start start index; o_grant one-hot,
// o_idx encoded grant, o_any set when any request is present.
module rr_priority_picker
   import cva5_types::*;
#(
   parameter int WIDTH = 4,
   parameter int IDX_W = idx_w(WIDTH)
) (
   input  logic [WIDTH-1:0] i_req,
   input  logic [IDX_W-1:0] i_start,
   output logic [WIDTH-1:0] o_grant,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   logic [IDX_W:0]   w_sum;
   logic [IDX_W-1:0] w_pos;

   // Walk offsets from far to near so the nearest request wins last.
   // The sum is one bit wider so start+offset never overflows before
   // the explicit wrap compare.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_sum   = '0;
      w_pos   = '0;
      for (int off = WIDTH - 1; off >= 0; off--) begin
         w_sum = {1'b0, i_start} + (IDX_W+1)'(off);
         if (w_sum >= (IDX_W+1)'(WIDTH))
            w_sum = w_sum - (IDX_W+1)'(WIDTH);
         w_pos = w_sum[IDX_W-1:0];
         if (i_req[w_pos]) begin
            o_grant        = '0;
            o_grant[w_pos] = 1'b1;
            o_idx          = w_pos;
            o_any          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_group_arbiter.sv
// Arbitrates multicycle units onto the shared writeback group. The unit
// holding the oldest in-flight ID wins; otherwise round-robin.
// Ports: clk, rst (async active-low); unit_done/unit_id/unit_rd requests,
// unit_ack one-hot accept; oldest_id; registered wb_valid/wb_id/wb_data;
// deferred_count saturating count of cycles with an un-granted done unit.
module wb_group_arbiter
   import cva5_types::*;
#(
   parameter int NUM_UNITS   = 4,
   parameter int DATA_W      = 32,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_UNITS-1:0]   unit_done,
   input  id_t                    unit_id [NUM_UNITS],
   input  logic [DATA_W-1:0]      unit_rd [NUM_UNITS],
   output logic [NUM_UNITS-1:0]   unit_ack,
   input  id_t                    oldest_id,
   output logic                   wb_valid,
   output id_t                    wb_id,
   output logic [DATA_W-1:0]      wb_data,
   output logic [STALL_CNT_W-1:0] deferred_count
);

   localparam int RR_W = idx_w(NUM_UNITS);

   logic [RR_W-1:0]        r_rr_ptr;
   logic                   r_wb_valid;
   id_t                    r_wb_id;
   logic [DATA_W-1:0]      r_wb_data;
   logic [STALL_CNT_W-1:0] r_def_cnt;

   logic [NUM_UNITS-1:0]   w_match;
   logic                   w_ovr_any;
   logic [RR_W-1:0]        w_ovr_idx;
   logic [NUM_UNITS-1:0]   w_rr_grant;
   logic [RR_W-1:0]        w_rr_idx;
   logic                   w_rr_any;
   logic                   w_any;
   logic [RR_W-1:0]        w_grant_idx;
   logic [RR_W-1:0]        w_rr_next;
   logic                   w_multi;

   always_comb begin
      for (int i = 0; i < NUM_UNITS; i++)
         w_match[i] = unit_done[i] && (unit_id[i] == oldest_id);
   end

   // Lowest matching index: scan downward so index 0 is assigned last.
   always_comb begin
      w_ovr_idx = '0;
      for (int i = NUM_UNITS - 1; i >= 0; i--)
         if (w_match[i])
            w_ovr_idx = RR_W'(i);
   end

   assign w_ovr_any = |w_match;

   rr_priority_picker #(
      .WIDTH (NUM_UNITS),
      .IDX_W (RR_W)
   ) u_picker (
      .i_req   (unit_done),
      .i_start (r_rr_ptr),
      .o_grant (w_rr_grant),
      .o_idx   (w_rr_idx),
      .o_any   (w_rr_any)
   );

   assign w_any       = w_rr_any;
   assign w_grant_idx = w_ovr_any ? w_ovr_idx : w_rr_idx;

   // Acks are masked in reset so units never see a dropped handshake.
   always_comb begin
      unit_ack = '0;
      if (rst && w_any)
         unit_ack[w_grant_idx] = 1'b1;
   end

   always_comb begin
      if (NUM_UNITS == 1)
         w_rr_next = '0;
      else if (w_grant_idx == RR_W'(NUM_UNITS - 1))
         w_rr_next = '0;
      else
         w_rr_next = w_grant_idx + RR_W'(1);
   end

   // More than one bit set means someone waits this cycle.
   assign w_multi =
      (unit_done & (unit_done - NUM_UNITS'(1))) != '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rr_ptr   <= '0;
         r_wb_valid <= 1'b0;
         r_wb_id    <= '0;
         r_wb_data  <= '0;
         r_def_cnt  <= '0;
      end else begin
         r_wb_valid <= w_any;
         if (w_any) begin
            r_rr_ptr  <= w_rr_next;
            r_wb_id   <= unit_id[w_grant_idx];
            r_wb_data <= unit_rd[w_grant_idx];
         end
         if (w_multi && (r_def_cnt != '1))
            r_def_cnt <= r_def_cnt + STALL_CNT_W'(1);
      end
   end

   assign wb_valid       = r_wb_valid;
   assign wb_id          = r_wb_id;
   assign wb_data        = r_wb_data;
   assign deferred_count = r_def_cnt;

endmodule

// File: tb/tb_wb_group_arbiter.sv
// Directed bench for wb_group_arbiter with a writeback scoreboard.
// Ports: none; drives the DUT with four units and a 4-bit stall counter.
module tb_wb_group_arbiter;
   import cva5_types::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  unit_done;
   id_t         unit_id [4];
   logic [31:0] unit_rd [4];
   logic [3:0]  unit_ack;
   id_t         oldest_id;
   logic        wb_valid;
   id_t         wb_id;
   logic [31:0] wb_data;
   logic [3:0]  deferred_count;

   typedef struct packed {
      logic        v;
      id_t         id;
      logic [31:0] d;
   } exp_t;

   exp_t        q[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [3:0]  m_cnt = '0;
   id_t         m_id = '0;
   logic [31:0] m_data = '0;

   wb_group_arbiter #(
      .NUM_UNITS   (4),
      .DATA_W      (32),
      .STALL_CNT_W (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .unit_done      (unit_done),
      .unit_id        (unit_id),
      .unit_rd        (unit_rd),
      .unit_ack       (unit_ack),
      .oldest_id      (oldest_id),
      .wb_valid       (wb_valid),
      .wb_id          (wb_id),
      .wb_data        (wb_data),
      .deferred_count (deferred_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_unit(input int u, input id_t id);
      unit_id[u] = id;
      unit_rd[u] = 32'hD000_0000 | (32'(id) << 8) | 32'(u);
   endtask

   // Sample at negedge, retire previous expectation, queue this one.
   task automatic step(input logic [3:0] exp_ack, input bit drop,
                       input string tag);
      exp_t e;
      int   g;
      @(negedge clk);
      check({tag, " ack"}, 64'(unit_ack), 64'(exp_ack));
      check({tag, " dcnt"}, 64'(deferred_count), 64'(m_cnt));
      if (q.size() > 0) begin
         e = q.pop_front();
         check({tag, " wb"}, 64'({wb_valid, wb_id, wb_data}), 64'(e));
      end
      g = -1;
      for (int i = 0; i < 4; i++)
         if (exp_ack[i]) g = i;
      if (g >= 0) begin
         m_id   = unit_id[g];
         m_data = unit_rd[g];
         q.push_back({1'b1, m_id, m_data});
      end else begin
         q.push_back({1'b0, m_id, m_data});
      end
      if (((unit_done & (unit_done - 4'd1)) != 4'd0) && (m_cnt != 4'hF))
         m_cnt++;
      @(posedge clk);
      #1;
      if (drop) unit_done = unit_done & ~exp_ack;
   endtask

   task automatic model_reset();
      q.delete();
      q.push_back('0);
      m_id   = '0;
      m_data = '0;
      m_cnt  = '0;
   endtask

   initial begin
      unit_done = 4'b0000;
      oldest_id = '0;
      for (int i = 0; i < 4; i++) set_unit(i, id_t'(5 + i));
      #1;
      unit_done = 4'b1111;
      repeat (3) begin
         @(negedge clk);
         check("rst ack", 64'(unit_ack), 64'(0));
         check("rst wbv", 64'(wb_valid), 64'(0));
         check("rst dcnt", 64'(deferred_count), 64'(0));
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();

      step(4'b0001, 1'b1, "rr0");
      step(4'b0010, 1'b1, "rr1");
      step(4'b0100, 1'b1, "rr2");
      step(4'b1000, 1'b1, "rr3");
      step(4'b0000, 1'b0, "idle");
      check("rr dcnt3", 64'(deferred_count), 64'(3));

      set_unit(1, id_t'(3));
      set_unit(2, id_t'(9));
      oldest_id = id_t'(9);
      unit_done = 4'b0110;
      step(4'b0100, 1'b1, "ovr");
      check("ovr rr", 64'(dut.r_rr_ptr), 64'(3));

      oldest_id = id_t'(0);
      set_unit(3, id_t'(10));
      set_unit(0, id_t'(11));
      unit_done = unit_done | 4'b1001;
      step(4'b1000, 1'b1, "wrap3");
      step(4'b0001, 1'b1, "wrap0");
      check("wrap rr", 64'(dut.r_rr_ptr), 64'(1));
      step(4'b0010, 1'b1, "wrap1");

      for (int i = 0; i < 4; i++) set_unit(i, id_t'(1 + i));
      unit_done = 4'b1111;
      step(4'b0100, 1'b1, "pre");
      check("pre wbv", 64'(wb_valid), 64'(1));
      #2;
      rst = 1'b0;
      #1;
      check("arst wbv", 64'(wb_valid), 64'(0));
      check("arst rr", 64'(dut.r_rr_ptr), 64'(0));
      check("arst ack", 64'(unit_ack), 64'(0));
      unit_done = 4'b0000;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;

      set_unit(0, id_t'(12));
      set_unit(1, id_t'(13));
      unit_done = 4'b0011;
      for (int i = 0; i < 20; i++)
         step((i % 2 == 0) ? 4'b0001 : 4'b0010, 1'b0, "sat");
      check("sat dcnt15", 64'(deferred_count), 64'(15));
      unit_done = 4'b0000;
      step(4'b0000, 1'b0, "drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
